// File: rtl/mask_chunk_seq_pkg.sv
// Shared types and helpers for the mask chunk sequencer: SEW encodings,
// elements-per-beat helper and the sequencer state enum.
package mask_chunk_seq_pkg;

    localparam logic [1:0] SEW_E8  = 2'b00;
    localparam logic [1:0] SEW_E16 = 2'b01;
    localparam logic [1:0] SEW_E32 = 2'b10;
    localparam logic [1:0] SEW_E64 = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ZERO  = 3'd1,
        FETCH = 3'd2,
        WAIT  = 3'd3,
        EMIT  = 3'd4
    } state_e;

    // Mask elements carried by one beat of beat_bytes bytes at the given SEW.
    function automatic int unsigned epb(input int unsigned beat_bytes, input logic [1:0] sew);
        case (sew)
            SEW_E8:  return beat_bytes;
            SEW_E16: return beat_bytes >> 1;
            SEW_E32: return beat_bytes >> 2;
            SEW_E64: return beat_bytes >> 3;
            default: return beat_bytes;
        endcase
    endfunction

endpackage

// File: rtl/mask_chunk_seq_expand.sv
// Combinational beat former: widens each mask bit of the current slice to its
// element's bytes and zeroes every element at or beyond vl.
module mask_beat_expand #(
    parameter int BEAT_BYTES = 8,
    parameter int EW         = 13,
    parameter int VL_WIDTH   = 12,
    parameter int SEW_WIDTH  = 2
) (
    input  logic [BEAT_BYTES-1:0] slice_i,
    input  logic [EW-1:0]         elem_base_i,
    input  logic [VL_WIDTH-1:0]   vl_i,
    input  logic [SEW_WIDTH-1:0]  sew_i,
    output logic [BEAT_BYTES-1:0] m0_o
);

    localparam int IW = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 1;

    genvar gi;
    generate
        for (gi = 0; gi < BEAT_BYTES; gi++) begin : g_byte
            logic [IW-1:0] elem_off;
            // Byte gi belongs to element gi >> sew within this beat.
            assign elem_off = IW'(gi) >> sew_i;
            assign m0_o[gi] = slice_i[elem_off] & ((elem_base_i + EW'(elem_off)) < EW'(vl_i));
        end
    endgenerate

endmodule

// File: rtl/mask_chunk_seq.sv
// Mask chunk sequencer: fetches packed mask words and emits one byte-mask beat
// per cycle. Optional macro MASK_CHUNK_SEQ_VM_EN adds cmd_vm (unmasked mode).
module mask_chunk_seq
    import mask_chunk_seq_pkg::*;
#(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH = 32,
    parameter int SEW_WIDTH      = 2,
    parameter int VL_WIDTH       = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [VL_WIDTH-1:0]         cmd_vl,
    input  logic [SEW_WIDTH-1:0]        cmd_sew,
    input  logic [REQ_ADDR_WIDTH-1:0]   cmd_mask_addr,
    input  logic [REQ_ADDR_WIDTH-1:0]   cmd_dst_addr,
`ifdef MASK_CHUNK_SEQ_VM_EN
    input  logic                        cmd_vm,
`endif
    output logic                        rd_req,
    output logic [REQ_ADDR_WIDTH-1:0]   rd_addr,
    input  logic                        rd_valid,
    input  logic [REQ_DATA_WIDTH-1:0]   rd_data,
    output logic [REQ_DATA_WIDTH/8-1:0] out_m0,
    output logic                        out_valid,
    output logic [SEW_WIDTH-1:0]        out_sew,
    output logic                        out_start,
    output logic                        out_end,
    output logic [REQ_ADDR_WIDTH-1:0]   out_addr,
    output logic                        busy
);

    localparam int BB = REQ_DATA_WIDTH / 8;
    localparam int PW = $clog2(REQ_DATA_WIDTH) + 1;
    localparam int EW = VL_WIDTH + 1;

    state_e                      state_q;
    logic [VL_WIDTH-1:0]         vl_q;
    logic [VL_WIDTH-1:0]         word_idx_q;
    logic [SEW_WIDTH-1:0]        sew_q;
    logic [REQ_ADDR_WIDTH-1:0]   mask_addr_q;
    logic [REQ_ADDR_WIDTH-1:0]   rd_addr_q;
    logic [REQ_ADDR_WIDTH-1:0]   out_addr_q;
    logic [EW-1:0]               elem_base_q;
    logic [PW-1:0]               bit_ptr_q;
    logic [REQ_DATA_WIDTH-1:0]   buf_q;
    logic                        vm_q;
    logic                        rd_req_q;
    logic                        out_valid_q;
    logic                        out_start_q;
    logic                        out_end_q;
    logic [BB-1:0]               out_m0_q;

    logic                        cmd_vm_d;
    logic [EW-1:0]               epb_d;
    logic [EW-1:0]               elem_next_d;
    logic [PW-1:0]               bit_next_d;
    logic [VL_WIDTH-1:0]         word_next_d;
    logic                        last_d;
    logic                        word_done_d;
    logic [BB-1:0]               slice_d;
    logic [BB-1:0]               beat_m0_d;

`ifdef MASK_CHUNK_SEQ_VM_EN
    assign cmd_vm_d = cmd_vm;
`else
    assign cmd_vm_d = 1'b0;
`endif

    assign epb_d       = EW'(epb(BB, sew_q));
    assign elem_next_d = elem_base_q + epb_d;
    assign bit_next_d  = bit_ptr_q + PW'(epb_d);
    assign word_next_d = word_idx_q + 1'b1;
    assign last_d      = elem_next_d >= EW'(vl_q);
    assign word_done_d = bit_next_d == PW'(REQ_DATA_WIDTH);
    assign slice_d     = BB'(buf_q >> bit_ptr_q);

    mask_beat_expand #(
        .BEAT_BYTES (BB),
        .EW         (EW),
        .VL_WIDTH   (VL_WIDTH),
        .SEW_WIDTH  (SEW_WIDTH)
    ) u_expand (
        .slice_i     (slice_d),
        .elem_base_i (elem_base_q),
        .vl_i        (vl_q),
        .sew_i       (sew_q),
        .m0_o        (beat_m0_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vl_q        <= '0;
            word_idx_q  <= '0;
            sew_q       <= '0;
            mask_addr_q <= '0;
            rd_addr_q   <= '0;
            out_addr_q  <= '0;
            elem_base_q <= '0;
            bit_ptr_q   <= '0;
            buf_q       <= '0;
            vm_q        <= 1'b0;
            rd_req_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_end_q   <= 1'b0;
            out_m0_q    <= '0;
        end else begin
            rd_req_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_end_q   <= 1'b0;
            out_m0_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        vl_q        <= cmd_vl;
                        sew_q       <= cmd_sew;
                        mask_addr_q <= cmd_mask_addr;
                        out_addr_q  <= cmd_dst_addr;
                        vm_q        <= cmd_vm_d;
                        elem_base_q <= '0;
                        bit_ptr_q   <= '0;
                        word_idx_q  <= '0;
                        if (cmd_vl == '0) begin
                            state_q <= ZERO;
                        end else if (cmd_vm_d) begin
                            buf_q   <= '1;
                            state_q <= EMIT;
                        end else begin
                            state_q   <= FETCH;
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= cmd_mask_addr;
                        end
                    end
                end
                ZERO: begin
                    out_valid_q <= 1'b1;
                    out_start_q <= 1'b1;
                    out_end_q   <= 1'b1;
                    state_q     <= IDLE;
                end
                FETCH: state_q <= WAIT;
                WAIT: begin
                    if (rd_valid) begin
                        buf_q   <= rd_data;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    out_valid_q <= 1'b1;
                    out_m0_q    <= beat_m0_d;
                    out_start_q <= (elem_base_q == '0);
                    out_end_q   <= last_d;
                    elem_base_q <= elem_next_d;
                    bit_ptr_q   <= bit_next_d;
                    if (last_d) begin
                        state_q <= IDLE;
                    end else if (word_done_d) begin
                        // Word exhausted: unmasked mode keeps streaming ones.
                        bit_ptr_q  <= '0;
                        word_idx_q <= word_next_d;
                        if (!vm_q) begin
                            state_q   <= FETCH;
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= mask_addr_q
                                       + REQ_ADDR_WIDTH'(word_next_d) * REQ_ADDR_WIDTH'(BB);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_m0    = out_m0_q;
    assign out_start = out_start_q;
    assign out_end   = out_end_q;
    assign out_sew   = sew_q;
    assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_mask_chunk_seq.sv
// Bench for mask_chunk_seq: directed and random commands against an
// element-indexed reference model; a memory responder answers reads.
module tb_mask_chunk_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_vl;
    logic [1:0]  cmd_sew;
    logic [31:0] cmd_mask_addr;
    logic [31:0] cmd_dst_addr;
`ifdef MASK_CHUNK_SEQ_VM_EN
    logic        cmd_vm;
`endif
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic [7:0]  out_m0;
    logic        out_valid;
    logic [1:0]  out_sew;
    logic        out_start;
    logic        out_end;
    logic [31:0] out_addr;
    logic        busy;

    always #5 clk = ~clk;

    mask_chunk_seq dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_vl        (cmd_vl),
        .cmd_sew       (cmd_sew),
        .cmd_mask_addr (cmd_mask_addr),
        .cmd_dst_addr  (cmd_dst_addr),
`ifdef MASK_CHUNK_SEQ_VM_EN
        .cmd_vm        (cmd_vm),
`endif
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .out_m0        (out_m0),
        .out_valid     (out_valid),
        .out_sew       (out_sew),
        .out_start     (out_start),
        .out_end       (out_end),
        .out_addr      (out_addr),
        .busy          (busy)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] mem [65];
    logic [7:0]  obs_m0 [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat k as a list of elements: byte b carries element k*epb + b/bytes_per_elem.
    function automatic logic [7:0] exp_beat(input int vl, input int sew, input bit vm, input int k);
        int         epb_n = 8 >> sew;
        int         bpe   = 8 / epb_n;
        logic [7:0] r     = '0;
        for (int b = 0; b < 8; b++) begin
            int idx = k * epb_n + b / bpe;
            if (idx < vl) r[b] = vm ? 1'b1 : mem[idx / 64][idx % 64];
        end
        return r;
    endfunction

    task automatic randomize_mem();
        for (int i = 0; i < 65; i++) mem[i] = {$urandom, $urandom};
    endtask

    task automatic run_cmd(input int vl, input int sew, input int delay, input bit vm,
                           input bit busy_poke, input int rst_after);
        int          epb_n  = 8 >> sew;
        int          nbeats = (vl == 0) ? 1 : (vl + epb_n - 1) / epb_n;
        int          nwords = (vl == 0 || vm) ? 0 : (vl + 63) / 64;
        logic [31:0] base   = $urandom & 32'hFFFF_FFF8;
        logic [31:0] dst    = $urandom;
        int          k      = 0;
        int          reqs   = 0;
        int          cnt    = 0;
        int          last_it = 0;
        bit          done   = 0;
        bit          new_word;
        obs_m0.delete();
        cmd_valid     = 1'b1;
        cmd_vl        = 12'(vl);
        cmd_sew       = 2'(sew);
        cmd_mask_addr = base;
        cmd_dst_addr  = dst;
`ifdef MASK_CHUNK_SEQ_VM_EN
        cmd_vm        = vm;
`endif
        @(negedge clk);
        cmd_valid     = 1'b0;
        cmd_vl        = 12'($urandom);
        cmd_sew       = 2'($urandom);
        cmd_mask_addr = $urandom;
        cmd_dst_addr  = $urandom;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", cmd_ready, 0);
        for (int it = 0; it < 20000 && !done; it++) begin
            if (out_valid) begin
                chk("m0", out_m0, exp_beat(vl, sew, vm, k));
                chk("start", out_start, k == 0);
                chk("end", out_end, k == nbeats - 1);
                chk("sew", out_sew, sew);
                chk("addr", out_addr, dst);
                if (k == 0) begin
                    chk("first_latency", it, (vm || vl == 0) ? 1 : 3 + delay);
                end else begin
                    new_word = !vm && ((k * epb_n) % 64 == 0);
                    chk("gap", it - last_it - 1, new_word ? 2 + delay : 0);
                end
                obs_m0.push_back(out_m0);
                last_it = it;
                k++;
                if (out_end) begin
                    done = 1;
                    chk("ready_at_end", cmd_ready, 1);
                    chk("beat_count", k, nbeats);
                    chk("req_count", reqs, nwords);
                end
            end else begin
                chk("quiet_outputs", {out_m0, out_start, out_end}, 0);
            end
            rd_valid = 1'b0;
            rd_data  = {$urandom, $urandom};
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = mem[(reqs - 1) % 65];
                end
            end
            if (rd_req) begin
                chk("rd_addr", rd_addr, base + 32'(reqs * 8));
                reqs++;
                cnt = 1 + delay;
            end
            cmd_valid = busy_poke && it == 0;
            if (cmd_valid) cmd_vl = 12'($urandom_range(1, 4095));
            if (rst_after > 0 && k == rst_after && !done) begin
                rst      = 1'b1;
                rd_valid = 1'b0;
                cmd_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ready", cmd_ready, 1);
                chk("rst_rd_req", rd_req, 0);
                rd_valid = 1'b1;
                done = 1;
            end
            if (!done) @(negedge clk);
        end
        chk("completed_in_budget", done, 1);
        @(negedge clk);
        rd_valid  = 1'b0;
        cmd_valid = 1'b0;
        chk("after_out_valid", out_valid, 0);
        chk("after_rd_req", rd_req, 0);
        chk("after_busy", busy, 0);
    endtask

    initial begin
        int vl_r;
        int sew_r;
        bit vm_r;
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_vl        = '0;
        cmd_sew       = '0;
        cmd_mask_addr = '0;
        cmd_dst_addr  = '0;
`ifdef MASK_CHUNK_SEQ_VM_EN
        cmd_vm        = 1'b0;
`endif
        rd_valid      = 1'b0;
        rd_data       = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rd_req", rd_req, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_out", {out_valid, out_m0, out_start, out_end, out_sew}, 0);
        chk("reset_out_addr", out_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        mem[0] = '1;
        run_cmd(10, 0, 0, 0, 0, 0);
        chk("t1_beat0", obs_m0[0], 8'hFF);
        chk("t1_beat1", obs_m0[1], 8'h03);

        mem[0] = 64'h5;
        run_cmd(3, 3, 0, 0, 0, 0);
        chk("t2_beat1", obs_m0[1], 8'h00);
        chk("t2_beat2", obs_m0[2], 8'hFF);

        run_cmd(0, $urandom_range(0, 3), 0, 0, 0, 0);

        mem[0] = '1;
        mem[1] = '1;
        run_cmd(70, 0, 0, 0, 0, 0);
        chk("t4_last", obs_m0[8], 8'h3F);

        randomize_mem();
        rd_valid = 1'b1;
        rd_data  = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        rd_valid = 1'b0;
        chk("stray_idle_busy", busy, 0);
        run_cmd($urandom_range(65, 200), $urandom_range(0, 3), 5, 0, 1, 0);

        run_cmd(70, 0, 0, 0, 0, 3);
        run_cmd(10, 0, 0, 0, 0, 0);

`ifdef MASK_CHUNK_SEQ_VM_EN
        run_cmd(5, 1, 0, 1, 0, 0);
        chk("t7_beat0", obs_m0[0], 8'hFF);
        chk("t7_beat1", obs_m0[1], 8'h03);
`endif

        randomize_mem();
        run_cmd(4095, 3, 1, 0, 0, 0);

        for (int n = 0; n < 20; n++) begin
            randomize_mem();
            vl_r  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 700);
            sew_r = $urandom_range(0, 3);
`ifdef MASK_CHUNK_SEQ_VM_EN
            vm_r  = 1'($urandom_range(0, 1));
`else
            vm_r  = 1'b0;
`endif
            run_cmd(vl_r, sew_r, $urandom_range(0, 3), vm_r, 1'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mask_chunk_seq.md
Name: mask_chunk_seq

Overview:
- Upstream feeder for the mask-reduction units (vector population count, find-first).
- Accepts one mask-reduction command with vl, sew, mask source address and destination address.
- Fetches packed mask words from the vector register read port and emits one byte-granular mask beat per cycle (in_m0 format), with start/end/addr sideband.
- Tail elements (index >= vl) are always zeroed.

Parameters:
- REQ_DATA_WIDTH, 64: read-data width in bits; one mask word holds REQ_DATA_WIDTH mask bits; one beat is REQ_DATA_WIDTH/8 bits.
- REQ_ADDR_WIDTH, 32: address width.
- SEW_WIDTH, 2: sew encoding width (00=8b, 01=16b, 10=32b, 11=64b).
- VL_WIDTH, 12: width of vl.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_vl  in  VL_WIDTH  active element count
- cmd_sew  in  SEW_WIDTH  element width
- cmd_mask_addr  in  REQ_ADDR_WIDTH  address of mask word 0
- cmd_dst_addr  in  REQ_ADDR_WIDTH  result destination, passed through
- rd_req  out  1  single-cycle read request
- rd_addr  out  REQ_ADDR_WIDTH  read address
- rd_valid  in  1  read data valid
- rd_data  in  REQ_DATA_WIDTH  packed mask bits, bit i = element i of word
- out_m0  out  REQ_DATA_WIDTH/8  byte mask for the beat
- out_valid  out  1  beat valid
- out_sew  out  SEW_WIDTH  latched sew
- out_start  out  1  first beat of command
- out_end  out  1  last beat of command
- out_addr  out  REQ_ADDR_WIDTH  latched cmd_dst_addr
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset, state=IDLE and every output is 0 except cmd_ready=1. Reset mid-operation abandons the command, and any later rd_valid is ignored.
- Beat geometry:
  - EPB = (REQ_DATA_WIDTH/8) >> sew elements per beat; beats = ceil(vl/EPB).
  - One mask word supplies REQ_DATA_WIDTH/EPB beats.
- Command accept: cmd_valid & cmd_ready latches vl, sew, mask_addr, dst_addr, and clears elem_base and bit_ptr. cmd_valid while busy is ignored (no queueing).
- FSM:
  - IDLE -> FETCH on accept with vl>0.
  - IDLE -> ZERO on accept with vl==0.
  - ZERO: one beat with out_m0=0, start=end=1, no rd_req; -> IDLE.
  - FETCH: rd_req=1 for exactly one cycle, rd_addr = mask_addr + word_idx*(REQ_DATA_WIDTH/8); -> WAIT.
  - WAIT: hold until rd_valid, capture rd_data into word buffer; -> EMIT. rd_valid in any other state is ignored.
  - EMIT: one beat per cycle; elem_base += EPB, bit_ptr += EPB. Then:
    - -> IDLE when elem_base+EPB >= vl.
    - else -> FETCH when bit_ptr+EPB == REQ_DATA_WIDTH (word_idx++, bit_ptr=0).
    - else stay in EMIT.
- Beat formation, for e in 0..EPB-1:
  - act = buf[bit_ptr+e] & (elem_base+e < vl).
  - out_m0 bytes [(e<<sew) +: (1<<sew)] all = act.
  - Unused bytes are 0.
- Output timing:
  - Outputs are registered; out_valid is high the cycle after each EMIT/ZERO cycle.
  - out_start is on the first beat, out_end on the last; a single-beat command asserts both.
  - out_m0, out_start and out_end are 0 when out_valid=0.
  - out_sew and out_addr are held for the whole command.
- Latency: accept T0, rd_req T1, rd_valid at T2 earliest, first out_valid T4. Sustained rate is 1 beat/cycle within a word; each word crossing costs FETCH + WAIT cycles.
- No output backpressure: the consumer always accepts.

Optional Feature:
- Macro MASK_CHUNK_SEQ_VM_EN.
- Defined: adds input port cmd_vm (1 bit, latched on accept). When vm=1 (unmasked), the FSM skips FETCH/WAIT, the buffer is treated as all ones, and beats are emitted back-to-back starting the cycle after accept. Only the vl tail is zeroed, and rd_req never asserts.
- Undefined: no port; every vl>0 command reads the mask.

Decomposition:
- Shared package:
  - SEW encoding constants.
  - epb(sew) function.
  - FSM state enum (IDLE, ZERO, FETCH, WAIT, EMIT).
- Sub-module mask_beat_expand (combinational), which converts buffer slice + elem_base + vl + sew into out_m0. The sequencer owns all registers.

Test Plan:
1. vl=10, sew=00, rd_data=all ones -> one rd_req at mask_addr; beats out_m0=0xFF(start), 0x03(end).
2. vl=3, sew=11, rd_data=0b101 -> three beats 0xFF(start), 0x00, 0xFF(end); out_sew=11 throughout.
3. vl=0, any sew -> no rd_req; one beat out_m0=0x00 with start=end=1; cmd_ready back to 1 the following cycle.
4. vl=70, sew=00, word0=all ones, word1=all ones -> rd_req at base then base+8; 9 beats, last out_m0=0x3F; no out_valid gap other than the FETCH+WAIT gap.
5. rd_valid delayed 5 cycles; spurious rd_valid in IDLE; cmd_valid while busy -> rd_req is exactly one cycle, no out_valid during WAIT, stray data and command ignored.
6. rst asserted during EMIT of a 9-beat command -> next cycle out_valid=0, busy=0, cmd_ready=1; a new command completes correctly.
7. With MASK_CHUNK_SEQ_VM_EN: vm=1, vl=5, sew=01 -> rd_req never asserts; beats 0xFF(start), 0x03(end).
